// File: rtl/draw_brick_wall_if.sv
// Hit request/response channel between the ball logic (master) and the brick wall (slave).
interface draw_brick_wall_if #(
  parameter int ROWS = 6,
  parameter int COLS = 10
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          hit_valid;
  logic [RW-1:0] hit_row;
  logic [CW-1:0] hit_col;
  logic          hit_ready;
  logic          hit_resp_valid;
  logic          hit_resp_alive;

  modport master (
    output hit_valid, hit_row, hit_col,
    input  hit_ready, hit_resp_valid, hit_resp_alive
  );

  modport slave (
    input  hit_valid, hit_row, hit_col,
    output hit_ready, hit_resp_valid, hit_resp_alive
  );
endinterface

// File: rtl/draw_brick_wall.sv
// Brick-wall draw stage: overlays a ROWS x COLS brick grid on rgb_in with 2-cycle matched timing delay,
// tracks alive bricks and answers hit requests. Define BRICK_ROW_COLOR_EN for per-row red shading.
module draw_brick_wall #(
  parameter int          ROWS    = 6,
  parameter int          COLS    = 10,
  parameter int          X0      = 32,
  parameter int          Y0      = 64,
  parameter int          BRICK_W = 92,
  parameter int          BRICK_H = 28,
  parameter int          GAP     = 4,
  parameter logic [11:0] COLOR   = 12'hF80,
  localparam int         RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         CW      = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         NW      = $clog2(ROWS * COLS + 1)
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic [10:0]        hcount_in,
  input  logic [10:0]        vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  draw_brick_wall_if.slave   hit,
  input  logic               refill,
  output logic [10:0]        hcount_out,
  output logic [10:0]        vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out,
  output logic [NW-1:0]      bricks_left,
  output logic               wall_clear
);

  localparam int CELL_W = BRICK_W + GAP;
  localparam int CELL_H = BRICK_H + GAP;
  localparam int PXW    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int LNW    = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  logic [ROWS-1:0][COLS-1:0] alive;

  // Horizontal geometry counters
  logic           h_act,   h_act_c,   h_act_n;
  logic [CW-1:0]  h_col,   h_col_c,   h_col_n;
  logic [PXW-1:0] h_px,    h_px_c,    h_px_n;
  // Vertical geometry counters
  logic           v_act,   v_act_c;
  logic [RW-1:0]  v_row,   v_row_c;
  logic [LNW-1:0] v_ln,    v_ln_c;

  logic inside_h, inside_v;

  // Stage 1 registers
  logic [10:0]   s1_hcount, s1_vcount;
  logic          s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
  logic [11:0]   s1_rgb;
  logic          s1_inside;
  logic [RW-1:0] s1_row;
  logic [CW-1:0] s1_col;

  logic          brick_on;
  logic [11:0]   brick_rgb;

  logic          hit_accept, hit_in_range, hit_alive;

  // Counter values for the current pixel are bypassed on the start markers so that
  // the very first pixel of the wall already sees offset 0.
  always_comb begin
    h_act_c = h_act;
    h_col_c = h_col;
    h_px_c  = h_px;
    if (hcount_in == 11'(X0)) begin
      h_act_c = 1'b1;
      h_col_c = '0;
      h_px_c  = '0;
    end else if (hcount_in == '0) begin
      h_act_c = 1'b0;
    end

    h_act_n = h_act_c;
    h_col_n = h_col_c;
    h_px_n  = h_px_c;
    if (h_act_c) begin
      if (h_px_c == PXW'(CELL_W - 1)) begin
        h_px_n = '0;
        if (h_col_c == CW'(COLS - 1))
          h_act_n = 1'b0;
        else
          h_col_n = h_col_c + 1'b1;
      end else begin
        h_px_n = h_px_c + 1'b1;
      end
    end

    inside_h = h_act_c && (int'(h_px_c) < BRICK_W);
  end

  always_comb begin
    v_act_c = v_act;
    v_row_c = v_row;
    v_ln_c  = v_ln;
    if (vcount_in == 11'(Y0)) begin
      v_act_c = 1'b1;
      v_row_c = '0;
      v_ln_c  = '0;
    end else if (vcount_in == '0) begin
      v_act_c = 1'b0;
    end else if (hcount_in == '0 && v_act) begin
      if (v_ln == LNW'(CELL_H - 1)) begin
        v_ln_c = '0;
        if (v_row == RW'(ROWS - 1))
          v_act_c = 1'b0;
        else
          v_row_c = v_row + 1'b1;
      end else begin
        v_ln_c = v_ln + 1'b1;
      end
    end

    inside_v = v_act_c && (int'(v_ln_c) < BRICK_H);
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      h_act     <= 1'b0;
      h_col     <= '0;
      h_px      <= '0;
      v_act     <= 1'b0;
      v_row     <= '0;
      v_ln      <= '0;
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_rgb    <= '0;
      s1_inside <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
    end else begin
      h_act     <= h_act_n;
      h_col     <= h_col_n;
      h_px      <= h_px_n;
      v_act     <= v_act_c;
      v_row     <= v_row_c;
      v_ln      <= v_ln_c;
      s1_hcount <= hcount_in;
      s1_vcount <= vcount_in;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_hblnk  <= hblnk_in;
      s1_vblnk  <= vblnk_in;
      s1_rgb    <= rgb_in;
      s1_inside <= inside_h && inside_v;
      s1_row    <= v_row_c;
      s1_col    <= h_col_c;
    end
  end

  // Stage 2: alive lookup happens here so hits show on the next drawn pixel.
  always_comb begin
    brick_on = s1_inside && alive[s1_row][s1_col];
`ifdef BRICK_ROW_COLOR_EN
    brick_rgb = {COLOR[11:8] - 4'(s1_row), COLOR[7:0]};
`else
    brick_rgb = COLOR;
`endif
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s1_hcount;
      vcount_out <= s1_vcount;
      hsync_out  <= s1_hsync;
      vsync_out  <= s1_vsync;
      hblnk_out  <= s1_hblnk;
      vblnk_out  <= s1_vblnk;
      if (s1_hblnk || s1_vblnk)
        rgb_out <= '0;
      else if (brick_on)
        rgb_out <= brick_rgb;
      else
        rgb_out <= s1_rgb;
    end
  end

  assign hit.hit_ready = ~refill;

  always_comb begin
    hit_accept   = hit.hit_valid & ~refill;
    hit_in_range = (int'(hit.hit_row) < ROWS) && (int'(hit.hit_col) < COLS);
    hit_alive    = 1'b0;
    if (hit_in_range)
      hit_alive = alive[hit.hit_row][hit.hit_col];
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      alive              <= '1;
      bricks_left        <= NW'(ROWS * COLS);
      wall_clear         <= 1'b0;
      hit.hit_resp_valid <= 1'b0;
      hit.hit_resp_alive <= 1'b0;
    end else begin
      hit.hit_resp_valid <= hit_accept;
      hit.hit_resp_alive <= hit_accept & hit_alive;
      if (refill) begin
        alive       <= '1;
        bricks_left <= NW'(ROWS * COLS);
        wall_clear  <= 1'b0;
      end else begin
        if (hit_accept && hit_alive && bricks_left != '0) begin
          alive[hit.hit_row][hit.hit_col] <= 1'b0;
          bricks_left                     <= bricks_left - 1'b1;
        end
        wall_clear <= (bricks_left == '0);
      end
    end
  end

endmodule
